// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - Serial transmitter: start bit, LSB-first data bits, stop bit.
// The line level and its complement are both registered, so no input reaches q or q_not combinationally.
module serial_tx #(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic                 e,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] d,
   input  logic                 load,
   output logic                 ready,
   output logic                 q,
   output logic                 q_not
);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [5:0]  IDX_LAST = 6'(DATA_BITS - 1);

   state_t               r_state, w_state_nxt;
   logic [15:0]          r_cnt, w_cnt_nxt;
   logic [5:0]           r_idx, w_idx_nxt;
   logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
   logic                 r_q, w_q_nxt;
   logic                 r_q_not;
   logic                 w_bit_done;

   assign w_bit_done = (r_cnt == CNT_LAST);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = w_bit_done ? 16'd0 : r_cnt + 16'd1;
      w_idx_nxt   = r_idx;
      w_shift_nxt = r_shift;
      w_q_nxt     = r_q;
      case (r_state)
         IDLE: begin
            w_cnt_nxt = 16'd0;
            w_q_nxt   = 1'b1;
            if (load) begin
               w_state_nxt = START;
               w_shift_nxt = d;
               w_idx_nxt   = 6'd0;
               w_q_nxt     = 1'b0;
            end
         end
         START: begin
            if (w_bit_done) begin
               w_state_nxt = DATA;
               w_q_nxt     = r_shift[0];
               w_shift_nxt = r_shift >> 1;
               w_idx_nxt   = 6'd0;
            end
         end
         DATA: begin
            // The shift register always holds the next bit to send in bit 0.
            if (w_bit_done) begin
               if (r_idx == IDX_LAST) begin
                  w_state_nxt = STOP;
                  w_q_nxt     = 1'b1;
               end else begin
                  w_idx_nxt   = r_idx + 6'd1;
                  w_q_nxt     = r_shift[0];
                  w_shift_nxt = r_shift >> 1;
               end
            end
         end
         STOP: begin
            if (w_bit_done) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_q_nxt     = 1'b1;
         end
      endcase
   end

   always_ff @(posedge e) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= 16'd0;
         r_idx   <= 6'd0;
         r_shift <= '0;
         r_q     <= 1'b1;
         r_q_not <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_shift <= w_shift_nxt;
         r_q     <= w_q_nxt;
         r_q_not <= ~w_q_nxt;
      end
   end

   assign ready = (r_state == IDLE);
   assign q     = r_q;
   assign q_not = r_q_not;

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter DATA_BITS, default 8, giving the data word width; legal range 1..32.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 4, giving clock cycles per serial bit; legal range 1..65535.

Ports (name, direction, width, meaning):
REQ-003 The block SHALL have port e, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port d, input, DATA_BITS bits: parallel word to transmit.
REQ-006 The block SHALL have port load, input, 1 bit: request to transmit d.
REQ-007 The block SHALL have port ready, output, 1 bit: high when the block accepts a load.
REQ-008 The block SHALL have port q, output, 1 bit: serial line, idle high.
REQ-009 The block SHALL have port q_not, output, 1 bit: bitwise complement of q at all times.

Function
REQ-010 The block SHALL implement an FSM with states IDLE, START, DATA and STOP.
REQ-011 In IDLE, ready SHALL be 1 and q SHALL be 1.
REQ-012 On a rising edge with load=1 and ready=1, the block SHALL capture d into an internal shift register, enter START, drive q=0 and ready=0 from that edge.
REQ-013 load while ready=0 SHALL be ignored; the frame in progress SHALL be unaffected, and no request SHALL be queued.
REQ-014 Changes on d after the capture edge SHALL NOT affect the frame in progress.
REQ-015 Each serial bit SHALL be held on q for exactly CLKS_PER_BIT cycles, timed by a bit-cycle counter that wraps from CLKS_PER_BIT-1 to 0.
REQ-016 Frame order SHALL be: one start bit (0), then DATA_BITS data bits LSB first, then one stop bit (1).
REQ-017 A bit-index counter SHALL advance in DATA and transition to STOP after bit DATA_BITS-1 completes.
REQ-018 At the end of the stop bit the FSM SHALL return to IDLE with ready=1; q SHALL remain 1 and produce no glitch.
REQ-019 ready SHALL be 0 for exactly (DATA_BITS+2)*CLKS_PER_BIT consecutive cycles per frame.
REQ-020 A load asserted in the first cycle ready returns to 1 SHALL be accepted, giving back-to-back frames with no idle gap beyond the stop bit.
REQ-021 With CLKS_PER_BIT=1, each bit SHALL last one cycle and the frame SHALL last DATA_BITS+2 cycles.
REQ-022 q and q_not SHALL be registered outputs with no combinational path from any input.

Reset
REQ-023 When rst=1 at a rising edge of e, the FSM SHALL enter IDLE; q=1, q_not=0, ready=1; all counters and the shift register SHALL be 0.
REQ-024 rst SHALL take priority over load in the same cycle, and that load SHALL be dropped.
REQ-025 rst asserted mid-frame SHALL abort the frame; q SHALL be 1 from the next edge, and no partial bits SHALL be resumed.

Verification
REQ-026 With DATA_BITS=8 and CLKS_PER_BIT=4, load 0xA5 from IDLE -> q = 0, 1,0,1,0,0,1,0,1, 1, each held 4 cycles; ready low for 40 cycles, then high.
REQ-027 Load 0x3C, then assert load with d=0xFF in cycle 10 -> transmitted bits remain 0x3C's (0,0,1,1,1,1,0,0); 0xFF is never sent.
REQ-028 Load 0x01, and assert load with d=0x80 in the first cycle ready=1 -> stop bit of the first frame is followed immediately by the start bit of 0x80; the two frames total 80 cycles.
REQ-029 Assert rst during data bit 3 of frame 0x55 -> next edge q=1, q_not=0, ready=1; a subsequent load 0x55 yields a complete, correct frame.
REQ-030 rst=1 and load=1 on the same edge -> IDLE, ready=1, q=1; no frame starts.
REQ-031 With DATA_BITS=8 and CLKS_PER_BIT=1, load 0xF0 -> q = 0,0,0,0,0,1,1,1,1,1 over 10 cycles, with q_not equal to ~q on every cycle.
